datapath_unit: RTL

Execution datapath driven directly by the processor control unit: consumes its control word (D_Addr, D_Wr, RF_s, RF_W_en, the three register addresses, ALU_s0) each cycle and performs the register-file, ALU and data-memory work. Holds a 16x16 register file, a 256x16 synchronous data memory and a 16-bit ALU with registered status flags. Sits between the control unit and the board display/debug logic.

---
 rtl/datapath_unit_if.sv | 33 +++
 rtl/datapath_unit.sv | 82 ++++++++
 2 files changed

// File: rtl/datapath_unit_if.sv
// Control word from the control unit and datapath observation bus.
interface datapath_unit_if #(
   parameter int DATA_W = 16
);
   logic [7:0]        D_Addr;
   logic              D_Wr;
   logic              RF_s;
   logic              RF_W_en;
   logic [3:0]        RF_W_Addr;
   logic [3:0]        RF_Ra_Addr;
   logic [3:0]        RF_Rb_Addr;
   logic [2:0]        ALU_s0;
   logic [DATA_W-1:0] Ra_Data;
   logic [DATA_W-1:0] Rb_Data;
   logic [DATA_W-1:0] ALU_Out;
   logic [DATA_W-1:0] Mem_Out;
   logic              Flag_Z;
   logic              Flag_N;

   modport master (
      output D_Addr, D_Wr, RF_s, RF_W_en,
      output RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, ALU_s0,
      input  Ra_Data, Rb_Data, ALU_Out, Mem_Out,
      input  Flag_Z, Flag_N
   );

   modport slave (
      input  D_Addr, D_Wr, RF_s, RF_W_en,
      input  RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, ALU_s0,
      output Ra_Data, Rb_Data, ALU_Out, Mem_Out,
      output Flag_Z, Flag_N
   );
endinterface

// File: rtl/datapath_unit.sv
// Register file, ALU and data memory datapath; define DP_RF_BYPASS_EN
// for write-through forwarding of memory loads onto the read ports.
module datapath_unit #(
   parameter int DATA_W     = 16,
   parameter int DMEM_DEPTH = 256
) (
   input logic            Clk,
   input logic            ResetN,
   datapath_unit_if.slave dp
);
   logic [DATA_W-1:0] rf  [16];
   logic [DATA_W-1:0] mem [DMEM_DEPTH];
   logic [DATA_W-1:0] mem_out_q;
   logic [DATA_W-1:0] ra_data;
   logic [DATA_W-1:0] rb_data;
   logic [DATA_W-1:0] alu_out;
   logic [DATA_W-1:0] wr_data;
   logic              flag_z_q;
   logic              flag_n_q;
   logic              fwd_a;
   logic              fwd_b;

   localparam logic [DATA_W-1:0] One = {{(DATA_W-1){1'b0}}, 1'b1};

   // Forwarding only from the memory path keeps the ALU out of the loop.
`ifdef DP_RF_BYPASS_EN
   assign fwd_a = dp.RF_W_en && dp.RF_s &&
                  (dp.RF_W_Addr == dp.RF_Ra_Addr);
   assign fwd_b = dp.RF_W_en && dp.RF_s &&
                  (dp.RF_W_Addr == dp.RF_Rb_Addr);
`else
   assign fwd_a = 1'b0;
   assign fwd_b = 1'b0;
`endif

   assign ra_data = fwd_a ? mem_out_q : rf[dp.RF_Ra_Addr];
   assign rb_data = fwd_b ? mem_out_q : rf[dp.RF_Rb_Addr];

   always_comb begin
      alu_out = '0;
      unique case (dp.ALU_s0)
         3'd0: alu_out = ra_data + rb_data;
         3'd1: alu_out = ra_data - rb_data;
         3'd2: alu_out = ra_data;
         3'd3: alu_out = ra_data ^ rb_data;
         3'd4: alu_out = ra_data | rb_data;
         3'd5: alu_out = ra_data & rb_data;
         3'd6: alu_out = ra_data + One;
         3'd7: alu_out = '0;
      endcase
   end

   assign wr_data = dp.RF_s ? mem_out_q : alu_out;

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         for (int i = 0; i < 16; i++) rf[i] <= '0;
         mem_out_q <= '0;
         flag_z_q  <= 1'b0;
         flag_n_q  <= 1'b0;
      end else begin
         if (dp.RF_W_en) rf[dp.RF_W_Addr] <= wr_data;
         mem_out_q <= mem[dp.D_Addr];
         if (dp.RF_W_en && !dp.RF_s) begin
            flag_z_q <= (alu_out == '0);
            flag_n_q <= alu_out[DATA_W-1];
         end
      end
   end

   // Array has no reset; contents survive ResetN.
   always_ff @(posedge Clk) begin
      if (ResetN && dp.D_Wr) mem[dp.D_Addr] <= ra_data;
   end

   assign dp.Ra_Data = ra_data;
   assign dp.Rb_Data = rb_data;
   assign dp.ALU_Out = alu_out;
   assign dp.Mem_Out = mem_out_q;
   assign dp.Flag_Z  = flag_z_q;
   assign dp.Flag_N  = flag_n_q;
endmodule
